// File: rtl/execute_stage.sv
// Execute stage: forwarding muxes, ALU, branch compare, and the EX/MEM pipeline register.
// Ports:
//   es_i_clk, es_i_rst_n        clock (rising edge), asynchronous active-low reset
//   es_i_stall, es_i_flush      hold the EX/MEM register / capture a bubble (flush wins)
//   es_i_valid                  ID/EX holds a real instruction
//   es_i_control                ALU operation code
//   es_i_rs_data, es_i_rt_data  register operands
//   es_i_imm, es_i_shamt        extended immediate, shift amount
//   es_i_alusrc, es_i_pc_plus4  operand B select (1 = imm), PC+4 for the branch target
//   es_i_fwd_a, es_i_fwd_b      forwarding selects (01 = EX/MEM result, 10 = MEM/WB data)
//   es_i_wb_data                MEM/WB result
//   es_i_rd, es_i_regwrite, es_i_memread, es_i_memwrite, es_i_memtoreg  control passed down the pipe
//   es_o_*                      registered EX/MEM outputs
module execute_stage #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned CWIDTH = 5
) (
  input  logic              es_i_clk,
  input  logic              es_i_rst_n,
  input  logic              es_i_stall,
  input  logic              es_i_flush,
  input  logic              es_i_valid,
  input  logic [CWIDTH-1:0] es_i_control,
  input  logic [DWIDTH-1:0] es_i_rs_data,
  input  logic [DWIDTH-1:0] es_i_rt_data,
  input  logic [DWIDTH-1:0] es_i_imm,
  input  logic [4:0]        es_i_shamt,
  input  logic              es_i_alusrc,
  input  logic [DWIDTH-1:0] es_i_pc_plus4,
  input  logic [1:0]        es_i_fwd_a,
  input  logic [1:0]        es_i_fwd_b,
  input  logic [DWIDTH-1:0] es_i_wb_data,
  input  logic [4:0]        es_i_rd,
  input  logic              es_i_regwrite,
  input  logic              es_i_memread,
  input  logic              es_i_memwrite,
  input  logic              es_i_memtoreg,
  output logic [DWIDTH-1:0] es_o_result,
  output logic [DWIDTH-1:0] es_o_store_data,
  output logic [DWIDTH-1:0] es_o_branch_target,
  output logic [4:0]        es_o_rd,
  output logic              es_o_regwrite,
  output logic              es_o_memread,
  output logic              es_o_memwrite,
  output logic              es_o_memtoreg,
  output logic              es_o_valid,
  output logic              es_o_branch_taken,
  output logic              es_o_overflow
);

  localparam int unsigned MSB = DWIDTH - 1;

  localparam logic [CWIDTH-1:0] OP_ADD  = CWIDTH'(0);
  localparam logic [CWIDTH-1:0] OP_SUB  = CWIDTH'(1);
  localparam logic [CWIDTH-1:0] OP_AND  = CWIDTH'(2);
  localparam logic [CWIDTH-1:0] OP_OR   = CWIDTH'(3);
  localparam logic [CWIDTH-1:0] OP_SLT  = CWIDTH'(5);
  localparam logic [CWIDTH-1:0] OP_SLTU = CWIDTH'(6);
  localparam logic [CWIDTH-1:0] OP_SLL  = CWIDTH'(7);
  localparam logic [CWIDTH-1:0] OP_SRL  = CWIDTH'(8);
  localparam logic [CWIDTH-1:0] OP_SRA  = CWIDTH'(9);
  localparam logic [CWIDTH-1:0] OP_EQ   = CWIDTH'(10);
  localparam logic [CWIDTH-1:0] OP_NEQ  = CWIDTH'(11);
  localparam logic [CWIDTH-1:0] OP_GE   = CWIDTH'(12);
  localparam logic [CWIDTH-1:0] OP_GEU  = CWIDTH'(13);
  localparam logic [CWIDTH-1:0] OP_BEQ  = CWIDTH'(15);
  localparam logic [CWIDTH-1:0] OP_BNE  = CWIDTH'(16);

  // EX/MEM pipeline register payload
  typedef struct packed {
    logic [DWIDTH-1:0] result;
    logic [DWIDTH-1:0] store_data;
    logic [DWIDTH-1:0] branch_target;
    logic [4:0]        rd;
    logic              regwrite;
    logic              memread;
    logic              memwrite;
    logic              memtoreg;
    logic              valid;
    logic              branch_taken;
    logic              overflow;
  } exmem_t;

  exmem_t            exmem_r;
  exmem_t            exmem_nxt;
  logic [DWIDTH-1:0] op_a;
  logic [DWIDTH-1:0] rt_fwd;
  logic [DWIDTH-1:0] op_b;
  logic [DWIDTH-1:0] add_res;
  logic [DWIDTH-1:0] sub_res;
  logic [DWIDTH-1:0] alu_res;
  logic              cmp_flag;
  logic              ovf;
  logic              br_taken;
  logic              bubble;

  // Forwarding: 01 takes the value currently held in EX/MEM, 10 the MEM/WB result
  always_comb begin
    op_a = es_i_rs_data;
    if (es_i_fwd_a == 2'b01)      op_a = exmem_r.result;
    else if (es_i_fwd_a == 2'b10) op_a = es_i_wb_data;
    rt_fwd = es_i_rt_data;
    if (es_i_fwd_b == 2'b01)      rt_fwd = exmem_r.result;
    else if (es_i_fwd_b == 2'b10) rt_fwd = es_i_wb_data;
    op_b = es_i_alusrc ? es_i_imm : rt_fwd;
  end

  assign add_res = op_a + op_b;
  assign sub_res = op_a - op_b;

  // ALU; unlisted codes fall back to ADDU with no flags
  always_comb begin
    alu_res  = add_res;
    cmp_flag = 1'b0;
    ovf      = 1'b0;
    br_taken = 1'b0;
    case (es_i_control)
      OP_ADD: begin
        alu_res = add_res;
        ovf     = (op_a[MSB] == op_b[MSB]) && (add_res[MSB] != op_a[MSB]);
      end
      OP_SUB: begin
        alu_res = sub_res;
        ovf     = (op_a[MSB] != op_b[MSB]) && (sub_res[MSB] != op_a[MSB]);
      end
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_SLT: begin
        cmp_flag = $signed(op_a) < $signed(op_b);
        alu_res  = {{(DWIDTH-1){1'b0}}, cmp_flag};
      end
      OP_SLTU: begin
        cmp_flag = op_a < op_b;
        alu_res  = {{(DWIDTH-1){1'b0}}, cmp_flag};
      end
      OP_SLL:  alu_res = op_b << es_i_shamt;
      OP_SRL:  alu_res = op_b >> es_i_shamt;
      OP_SRA:  alu_res = $unsigned($signed(op_b) >>> es_i_shamt);
      OP_EQ: begin
        cmp_flag = op_a == op_b;
        alu_res  = {{(DWIDTH-1){1'b0}}, cmp_flag};
      end
      OP_NEQ: begin
        cmp_flag = op_a != op_b;
        alu_res  = {{(DWIDTH-1){1'b0}}, cmp_flag};
      end
      OP_GE: begin
        cmp_flag = $signed(op_a) >= $signed(op_b);
        alu_res  = {{(DWIDTH-1){1'b0}}, cmp_flag};
      end
      OP_GEU: begin
        cmp_flag = op_a >= op_b;
        alu_res  = {{(DWIDTH-1){1'b0}}, cmp_flag};
      end
      OP_BEQ: begin
        alu_res  = '0;
        br_taken = op_a == op_b;
      end
      OP_BNE: begin
        alu_res  = '0;
        br_taken = op_a != op_b;
      end
      default: alu_res = add_res;
    endcase
  end

  // Next EX/MEM contents; a flush or an invalid slot becomes an all-zero bubble
  always_comb begin
    exmem_nxt = '0;
    bubble    = es_i_flush || !es_i_valid;
    if (!bubble) begin
      exmem_nxt.result        = alu_res;
      exmem_nxt.store_data    = rt_fwd;
      exmem_nxt.branch_target = es_i_pc_plus4 + (es_i_imm << 2);
      exmem_nxt.rd            = es_i_rd;
      exmem_nxt.regwrite      = es_i_regwrite && !ovf;
      exmem_nxt.memread       = es_i_memread;
      exmem_nxt.memwrite      = es_i_memwrite && !ovf;
      exmem_nxt.memtoreg      = es_i_memtoreg;
      exmem_nxt.valid         = 1'b1;
      exmem_nxt.branch_taken  = br_taken;
      exmem_nxt.overflow      = ovf;
    end
  end

  // EX/MEM register; stall holds unless a flush overrides it
  always_ff @(posedge es_i_clk or negedge es_i_rst_n) begin
    if (!es_i_rst_n)                   exmem_r <= '0;
    else if (!es_i_stall || es_i_flush) exmem_r <= exmem_nxt;
  end

  assign es_o_result        = exmem_r.result;
  assign es_o_store_data    = exmem_r.store_data;
  assign es_o_branch_target = exmem_r.branch_target;
  assign es_o_rd            = exmem_r.rd;
  assign es_o_regwrite      = exmem_r.regwrite;
  assign es_o_memread       = exmem_r.memread;
  assign es_o_memwrite      = exmem_r.memwrite;
  assign es_o_memtoreg      = exmem_r.memtoreg;
  assign es_o_valid         = exmem_r.valid;
  assign es_o_branch_taken  = exmem_r.branch_taken;
  assign es_o_overflow      = exmem_r.overflow;

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: directed cases plus random traffic against an arithmetic model.
module tb_execute_stage;

  logic        clk;
  logic        rst_n;
  logic        stall, flush, valid;
  logic [4:0]  control;
  logic [31:0] rs_data, rt_data, imm, pc_plus4, wb_data;
  logic [4:0]  shamt, rd;
  logic        alusrc, regwrite, memread, memwrite, memtoreg;
  logic [1:0]  fwd_a, fwd_b;

  logic [31:0] o_result, o_store, o_target;
  logic [4:0]  o_rd;
  logic        o_regwrite, o_memread, o_memwrite, o_memtoreg, o_valid, o_bt, o_ovf;

  typedef struct {
    logic [31:0] result;
    logic [31:0] store;
    logic [31:0] target;
    logic [4:0]  rd;
    logic        rw, mr, mw, mtr, valid, bt, ovf;
  } exp_t;

  exp_t q[$];
  exp_t mdl;
  int   n_tests = 0;
  int   n_fail  = 0;

  execute_stage #(.DWIDTH(32), .CWIDTH(5)) dut (
    .es_i_clk(clk), .es_i_rst_n(rst_n), .es_i_stall(stall), .es_i_flush(flush),
    .es_i_valid(valid), .es_i_control(control), .es_i_rs_data(rs_data),
    .es_i_rt_data(rt_data), .es_i_imm(imm), .es_i_shamt(shamt), .es_i_alusrc(alusrc),
    .es_i_pc_plus4(pc_plus4), .es_i_fwd_a(fwd_a), .es_i_fwd_b(fwd_b),
    .es_i_wb_data(wb_data), .es_i_rd(rd), .es_i_regwrite(regwrite),
    .es_i_memread(memread), .es_i_memwrite(memwrite), .es_i_memtoreg(memtoreg),
    .es_o_result(o_result), .es_o_store_data(o_store), .es_o_branch_target(o_target),
    .es_o_rd(o_rd), .es_o_regwrite(o_regwrite), .es_o_memread(o_memread),
    .es_o_memwrite(o_memwrite), .es_o_memtoreg(o_memtoreg), .es_o_valid(o_valid),
    .es_o_branch_taken(o_bt), .es_o_overflow(o_ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, got, want, $time);
    end
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, ".result"}, o_result, e.result);
    chk({tag, ".store"}, o_store, e.store);
    chk({tag, ".target"}, o_target, e.target);
    chk({tag, ".rd"}, 32'(o_rd), 32'(e.rd));
    chk({tag, ".regwrite"}, 32'(o_regwrite), 32'(e.rw));
    chk({tag, ".memread"}, 32'(o_memread), 32'(e.mr));
    chk({tag, ".memwrite"}, 32'(o_memwrite), 32'(e.mw));
    chk({tag, ".memtoreg"}, 32'(o_memtoreg), 32'(e.mtr));
    chk({tag, ".valid"}, 32'(o_valid), 32'(e.valid));
    chk({tag, ".branch_taken"}, 32'(o_bt), 32'(e.bt));
    chk({tag, ".overflow"}, 32'(o_ovf), 32'(e.ovf));
  endtask

  function automatic logic [31:0] flag32(input bit f);
    return f ? 32'd1 : 32'd0;
  endfunction

  // Reference model: what EX/MEM should hold after the next edge, given the current inputs
  function automatic exp_t model(input exp_t prev);
    exp_t        e;
    logic [31:0] a, rtv, b, r;
    longint      sa, sb, wide;
    bit          ov, bt;
    int          code;
    e = '{default: 0};
    if (stall && !flush) return prev;
    if (flush || !valid) return e;
    a   = (fwd_a == 2'd1) ? prev.result : (fwd_a == 2'd2) ? wb_data : rs_data;
    rtv = (fwd_b == 2'd1) ? prev.result : (fwd_b == 2'd2) ? wb_data : rt_data;
    b   = alusrc ? imm : rtv;
    sa  = longint'(signed'(a));
    sb  = longint'(signed'(b));
    ov  = 0;
    bt  = 0;
    code = int'(control);
    case (code)
      0:  begin wide = sa + sb; r = 32'(wide); ov = (wide > 64'sd2147483647) || (wide < -64'sd2147483648); end
      1:  begin wide = sa - sb; r = 32'(wide); ov = (wide > 64'sd2147483647) || (wide < -64'sd2147483648); end
      2:  r = a & b;
      3:  r = a | b;
      5:  r = flag32(sa < sb);
      6:  r = flag32(a < b);
      7:  r = 32'(64'(b) * (64'd1 << shamt));
      8:  r = 32'(64'(b) / (64'd1 << shamt));
      9:  r = (b >> shamt) | (b[31] ? ~(32'hFFFF_FFFF >> shamt) : 32'd0);
      10: r = flag32(a == b);
      11: r = flag32(a != b);
      12: r = flag32(sa >= sb);
      13: r = flag32(a >= b);
      15: begin r = 0; bt = (a == b); end
      16: begin r = 0; bt = (a != b); end
      default: r = 32'(64'(a) + 64'(b));
    endcase
    e.result = r;
    e.store  = rtv;
    e.target = 32'(64'(pc_plus4) + 64'(imm) * 64'd4);
    e.rd     = rd;
    e.rw     = regwrite && !ov;
    e.mr     = memread;
    e.mw     = memwrite && !ov;
    e.mtr    = memtoreg;
    e.valid  = 1;
    e.bt     = bt;
    e.ovf    = ov;
    return e;
  endfunction

  // Push the expectation for the next edge, then move to just after that edge
  task automatic step();
    mdl = model(mdl);
    q.push_back(mdl);
    @(posedge clk);
    #2;
  endtask

  task automatic clr_in();
    stall = 0; flush = 0; valid = 1; control = 5'd14;
    rs_data = 0; rt_data = 0; imm = 0; shamt = 0; alusrc = 0;
    pc_plus4 = 0; fwd_a = 0; fwd_b = 0; wb_data = 0; rd = 5'd1;
    regwrite = 1; memread = 0; memwrite = 0; memtoreg = 0;
  endtask

  // Monitor: every edge that follows a pushed expectation is compared
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk_all("sb", e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t zero;
    zero = '{default: 0};
    mdl  = zero;
    clr_in();
    rst_n = 0;
    #3;
    chk_all("reset", zero);
    #9 rst_n = 1;  // released between edges

    // Signed overflow vs. unchecked add
    clr_in(); rs_data = 32'h7FFF_FFFF; rt_data = 1; control = 0; memwrite = 1; step();
    chk("add_ovf.result", o_result, 32'h8000_0000);
    chk("add_ovf.overflow", 32'(o_ovf), 1);
    chk("add_ovf.regwrite", 32'(o_regwrite), 0);
    chk("add_ovf.memwrite", 32'(o_memwrite), 0);
    control = 14; step();
    chk("addu.overflow", 32'(o_ovf), 0);
    chk("addu.regwrite", 32'(o_regwrite), 1);

    // Forwarding from EX/MEM and MEM/WB
    clr_in(); rs_data = 32'h10; step();
    clr_in(); fwd_a = 2'b01; rs_data = 32'hDEAD; rt_data = 3; control = 1; step();
    chk("fwd01.result", o_result, 32'hD);
    clr_in(); fwd_b = 2'b10; wb_data = 5; rt_data = 32'hFF; rs_data = 7; control = 2; step();
    chk("fwd10.result", o_result, 32'h5);
    chk("fwd10.store", o_store, 32'h5);

    // Shifts and compares
    clr_in(); rt_data = 32'h8000_0000; shamt = 4; control = 9; step();
    chk("sra", o_result, 32'hF800_0000);
    control = 8; step();
    chk("srl", o_result, 32'h0800_0000);
    clr_in(); rs_data = 32'hFFFF_FFFF; rt_data = 1;
    control = 5;  step(); chk("slt", o_result, 1);
    control = 6;  step(); chk("sltu", o_result, 0);
    control = 12; step(); chk("ge", o_result, 0);
    control = 13; step(); chk("geu", o_result, 1);

    // Branches with negative offset
    clr_in(); rs_data = 9; rt_data = 9; pc_plus4 = 32'h100; imm = 32'hFFFF_FFFE; control = 15; step();
    chk("beq.taken", 32'(o_bt), 1);
    chk("beq.target", o_target, 32'hF8);
    chk("beq.result", o_result, 0);
    control = 16; step();
    chk("bne.taken", 32'(o_bt), 0);

    // Stall holds, stall+flush bubbles, invalid slot bubbles
    clr_in(); rs_data = 32'h1234; rt_data = 32'h1; rd = 5'd7; step();
    for (int i = 0; i < 3; i++) begin
      stall = 1; rs_data = $urandom; fwd_a = 2'b01; step();
      chk("stall.result", o_result, 32'h1235);
      chk("stall.rd", 32'(o_rd), 7);
    end
    stall = 1; flush = 1; step();
    chk("flush.valid", 32'(o_valid), 0);
    chk("flush.result", o_result, 0);
    clr_in(); valid = 0; regwrite = 1; memread = 1; rs_data = 5; step();
    chk("invalid.regwrite", 32'(o_regwrite), 0);
    chk("invalid.memread", 32'(o_memread), 0);

    // Asynchronous reset between edges, in-flight instruction discarded
    clr_in(); rs_data = 32'h55; rt_data = 32'h22; step();
    chk("prerst.result", o_result, 32'h77);
    #1 rst_n = 0;
    rs_data = 32'h999;
    #1 chk_all("async_rst", zero);
    mdl = zero;
    @(posedge clk);
    #1 chk("rst_held.result", o_result, 0);
    #2 rst_n = 1;
    clr_in(); rs_data = 32'h40; rt_data = 2; step();
    chk("post_rst.result", o_result, 32'h42);
    chk("post_rst.valid", 32'(o_valid), 1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      stall    = ($urandom % 8) == 0;
      flush    = ($urandom % 16) == 0;
      valid    = ($urandom % 8) != 0;
      control  = 5'($urandom);
      rs_data  = (($urandom % 4) == 0) ? 32'h7FFF_FFF0 + 32'($urandom % 32) : $urandom;
      rt_data  = (($urandom % 4) == 0) ? rs_data : $urandom;
      imm      = (($urandom % 2) == 0) ? 32'($signed(16'($urandom))) : $urandom;
      shamt    = 5'($urandom);
      alusrc   = 1'($urandom);
      pc_plus4 = $urandom;
      fwd_a    = 2'($urandom);
      fwd_b    = 2'($urandom);
      wb_data  = $urandom;
      rd       = 5'($urandom);
      regwrite = 1'($urandom);
      memread  = 1'($urandom);
      memwrite = 1'($urandom);
      memtoreg = 1'($urandom);
      step();
    end

    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 SHALL have parameter DWIDTH, default 32, datapath width.
REQ-002 SHALL have parameter CWIDTH, default 5, ALU control code width, driven by the ALU control decoder.
REQ-003 SHALL have port es_i_clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port es_i_rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports es_i_stall  input  1  hold EX/MEM register, and es_i_flush  input  1  insert bubble.
REQ-006 SHALL have port es_i_valid  input  1  ID/EX holds a real instruction.
REQ-007 SHALL have port es_i_control  input  CWIDTH  ALU operation code.
REQ-008 SHALL have ports es_i_rs_data and es_i_rt_data  input  DWIDTH  register operands.
REQ-009 SHALL have ports es_i_imm  input  DWIDTH  sign/zero-extended immediate, and es_i_shamt  input  5  shift amount.
REQ-010 SHALL have ports es_i_alusrc  input  1  operand B = imm when 1, and es_i_pc_plus4  input  DWIDTH.
REQ-011 SHALL have ports es_i_fwd_a and es_i_fwd_b  input  2  forwarding selects, and es_i_wb_data  input  DWIDTH  MEM/WB result.
REQ-012 SHALL have ports es_i_rd  input  5, and es_i_regwrite, es_i_memread, es_i_memwrite, es_i_memtoreg  input  1 each.
REQ-013 SHALL have registered outputs es_o_result, es_o_store_data, es_o_branch_target  DWIDTH; es_o_rd  5; es_o_regwrite, es_o_memread, es_o_memwrite, es_o_memtoreg, es_o_valid, es_o_branch_taken, es_o_overflow  1.

Function
REQ-014 SHALL resolve each forwarded operand as follows: fwd 00 -> register data; 01 -> current es_o_result; 10 -> es_i_wb_data; 11 -> register data.
REQ-015 SHALL use forwarded rt as operand B when es_i_alusrc=0 and es_i_imm when 1; es_o_store_data SHALL always capture forwarded rt.
REQ-016 SHALL decode control codes as follows: 0 ADD (signed, overflow-checked); 1 SUB (overflow-checked); 2 AND; 3 OR; 5 SLT; 6 SLTU; 14 ADDU (no overflow check).
REQ-017 SHALL decode shift codes as follows: 7 SLL, 8 SRL, 9 SRA, each shifting operand B by es_i_shamt.
REQ-018 SHALL decode compare codes as follows: 10 EQ, 11 NEQ, 12 GE signed, 13 GEU; result = {DWIDTH-1 zeros, flag}.
REQ-019 SHALL decode branch codes as follows: 15 BEQ, 16 BNE; result = 0, and branch_taken = (A==B) or (A!=B) respectively.
REQ-020 SHALL compute the branch target as es_i_pc_plus4 + (es_i_imm << 2), modulo 2^DWIDTH.
REQ-021 SHALL treat codes 4 and 17-31 as ADDU with no flags set.
REQ-022 SHALL set signed overflow when the operand signs agree (ADD), or differ (SUB), and the result sign differs from A.
REQ-023 SHALL, when overflow is set, capture es_o_overflow=1 and force es_o_regwrite=0 and es_o_memwrite=0.
REQ-024 SHALL give es_o_branch_taken=1 only for codes 15/16 with a true condition and es_i_valid=1.
REQ-025 SHALL register all outputs with 1-cycle latency from the ID/EX inputs.
REQ-026 SHALL gate regwrite, memread and memwrite with es_i_valid; when es_i_valid=0, outputs SHALL capture a bubble.
REQ-027 SHALL, on es_i_stall=1 with es_i_flush=0, hold every output unchanged, including forward path 01.
REQ-028 SHALL, on es_i_flush=1 (regardless of stall), capture a bubble: valid, regwrite, memread, memwrite, memtoreg, branch_taken and overflow = 0; data outputs = 0.
REQ-029 SHALL make es_o_valid follow es_i_valid on a normal update.

Reset
REQ-030 SHALL, while es_i_rst_n=0, asynchronously clear every output to 0 regardless of clock.
REQ-031 SHALL, on reset assertion mid-instruction, discard that instruction; the first capture after release SHALL be the next rising edge with rst_n=1.

Verification
REQ-032 SHALL verify ADD overflow: A=0x7FFFFFFF, B=1, code 0, regwrite=1 -> result 0x80000000, overflow=1, regwrite=0; same operands with code 14 -> overflow=0, regwrite=1.
REQ-033 SHALL verify forwarding: previous result 0x10, fwd_a=01, rt=3, code 1 -> result 0xD; fwd_b=10 with wb_data=5, code 2, A=7 -> result 5.
REQ-034 SHALL verify shift and compare: B=0x80000000, shamt=4 -> SRA 0xF8000000, SRL 0x08000000; A=0xFFFFFFFF, B=1 -> SLT 1, SLTU 0, GE 0, GEU 1.
REQ-035 SHALL verify branch: code 15, A=B=9, pc_plus4=0x100, imm=0xFFFFFFFE -> branch_taken=1, target 0xF8; code 16 with same inputs -> branch_taken=0.
REQ-036 SHALL verify stall/flush: stall for 3 cycles -> outputs constant; stall=1 and flush=1 together -> bubble, valid=0; es_i_valid=0 -> regwrite=0.
REQ-037 SHALL verify async reset: drive rst_n=0 between clock edges while outputs are non-zero -> all outputs 0 immediately; release, then the next edge captures new inputs.
